// File: rtl/overlay_chram_sched_if.sv
// Character-RAM write port bundle driven by the overlay scheduler.
interface overlay_chram_sched_if;
    logic        wr_ena;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;

    modport master (output wr_ena, wr_addr, wr_data, busy);
    modport slave  (input  wr_ena, wr_addr, wr_data, busy);
endinterface

// File: rtl/overlay_chram_sched.sv
// Cassette overlay chram write scheduler: watches tape position/length,
// queues wheel / progress-bar / hex-counter refresh jobs and serves them
// round-robin through the single chram write port.
module overlay_chram_sched #(
    parameter int WHEEL_A0 = 331,
    parameter int WHEEL_A1 = 340,
    parameter int BAR_BASE = 136,
    parameter int CNT_BASE = 200
) (
    input  logic                  i_clk,
    input  logic                  reset_n,
    input  logic                  ena,
    input  logic [24:0]           pos,
    input  logic [24:0]           max,
    overlay_chram_sched_if.master wr
);
    typedef enum logic {S_IDLE, S_RUN} state_t;
    typedef enum logic [1:0] {J_WHEEL = 2'd0, J_BAR = 2'd1, J_CNT = 2'd2} job_t;
    typedef struct packed {
        logic        ena;
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic [24:0] pos_r, max_r;
    logic        primed;
    logic        pos_ev, max_ev;
    logic [20:0] inc_pos;
    logic [4:0]  blocks;
    logic [2:0]  pend;          // bit index = job_t
    logic [2:0]  clr;
    job_t        rr, job, gsel;
    logic        grant;
    logic [2:0]  arb_s;
    state_t      state, state_n;
    logic [3:0]  idx;
    logic        last;
    logic [4:0]  blocks_s;
    logic [23:0] pos_s;
    logic        wheel_state;
    logic [4:0]  sh;
    logic [3:0]  nib;
    wr_t         wr_q, wr_n;
    logic        busy_q;

    // The first cycle after reset only primes pos_r/max_r, so the values
    // present at reset release do not count as changes.
    assign pos_ev = primed && (pos != pos_r);
    assign max_ev = primed && (max != max_r);

    // Change-detect history registers.
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_r  <= '0;
            max_r  <= '0;
            primed <= 1'b0;
        end else begin
            pos_r  <= pos;
            max_r  <= max;
            primed <= 1'b1;
        end
    end

    // Progress bar tracking: one block per (max/16)+1 position events, capped at 16.
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            inc_pos <= '0;
            blocks  <= '0;
        end else if (pos_ev) begin
            if (pos == '0) begin
                inc_pos <= '0;
                blocks  <= '0;
            end else if (inc_pos == {1'b0, max[23:4]}) begin
                inc_pos <= '0;
                if (blocks != 5'd16) blocks <= blocks + 5'd1;
            end else begin
                inc_pos <= inc_pos + 21'd1;
            end
        end
    end

    // Pending flags; a set on the grant edge beats the clear so the job reruns.
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) pend <= '0;
        else          pend <= (pend & ~clr) | {pos_ev, pos_ev | max_ev, pos_ev};
    end

    // Round-robin pick: rr holds the first requester to look at.
    always_comb begin
        grant = 1'b0;
        gsel  = J_WHEEL;
        arb_s = '0;
        for (int k = 2; k >= 0; k--) begin
            arb_s = {1'b0, rr} + 3'(k);
            if (arb_s >= 3'd3) arb_s = arb_s - 3'd3;
            if (pend[arb_s[1:0]]) begin
                grant = 1'b1;
                gsel  = job_t'(arb_s[1:0]);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    // Next state, grant clear and the write to register for the next cycle.
    always_comb begin
        state_n = state;
        clr     = '0;
        wr_n    = '0;
        last    = 1'b0;
        sh      = '0;
        nib     = '0;
        unique case (state)
            S_IDLE: begin
                if (ena && grant) begin
                    state_n = S_RUN;
                    clr     = 3'b001 << gsel;
                end
            end
            S_RUN: begin
                wr_n.ena = 1'b1;
                case (job)
                    J_WHEEL: begin
                        last      = (idx == 4'd1);
                        wr_n.addr = idx[0] ? 12'(WHEEL_A1) : 12'(WHEEL_A0);
                        wr_n.data = (wheel_state ^ idx[0]) ? 8'h2A : 8'h96;
                    end
                    J_BAR: begin
                        last      = (idx == 4'd15);
                        wr_n.addr = 12'(BAR_BASE) + 12'(idx);
                        wr_n.data = ({1'b0, idx} < blocks_s) ? 8'h7F : 8'hA6;
                    end
                    J_CNT: begin
                        last      = (idx == 4'd5);
                        sh        = 5'd20 - {idx[2:0], 2'b00};
                        nib       = pos_s[sh +: 4];
                        wr_n.addr = 12'(CNT_BASE) + 12'(idx);
                        wr_n.data = (nib < 4'd10) ? 8'h30 + {4'b0, nib} : 8'h37 + {4'b0, nib};
                    end
                    default: last = 1'b1;
                endcase
                if (last) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Job context: grant snapshots, write index, RR pointer, wheel phase.
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            job         <= J_WHEEL;
            rr          <= J_WHEEL;
            idx         <= '0;
            blocks_s    <= '0;
            pos_s       <= '0;
            wheel_state <= 1'b0;
        end else if (state == S_IDLE && state_n == S_RUN) begin
            job      <= gsel;
            rr       <= (gsel == J_CNT) ? J_WHEEL : job_t'(gsel + 2'd1);
            idx      <= '0;
            blocks_s <= blocks;
            pos_s    <= pos[23:0];
        end else if (state == S_RUN) begin
            idx <= idx + 4'd1;
            if (job == J_WHEEL && idx == 4'd1) wheel_state <= ~wheel_state;
        end
    end

    // Registered chram port; reset clears it asynchronously to abort a job.
    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q   <= '0;
            busy_q <= 1'b0;
        end else begin
            wr_q   <= wr_n;
            busy_q <= (state == S_RUN);
        end
    end

    assign wr.wr_ena  = wr_q.ena;
    assign wr.wr_addr = wr_q.addr;
    assign wr.wr_data = wr_q.data;
    assign wr.busy    = busy_q;
endmodule
